fetch_stage: RTL and testbench
==============================

# fetch_stage

Program-counter and fetch/decode pipeline-register block of the RISC core. It owns the PC, issues instruction-memory requests over a ready handshake, and holds the F and D instruction registers. It consumes the interrupt unit's `load_pc`/`interrupt_pc` redirect and feeds that unit its `pc` input. On any redirect it wipes F and D to NOP.

## Interface
- `RESET_PC`, 32'h00000000: PC value loaded on reset.
- `NOP`, 32'h00000000: instruction word injected into flushed F/D slots.
- `clk`  in  1: single clock, all state on posedge.
- `reset`  in  1: asynchronous, active-high.
- `stall`  in  1: hazard hold; F and D registers freeze.
- `branch_taken`  in  1: redirect request from execute.
- `branch_target`  in  32: target for `branch_taken`.
- `load_pc`  in  1: redirect request from the interrupt unit; sampled at posedge.
- `interrupt_pc`  in  32: target for `load_pc`.
- `imem_req`  out  1: fetch request valid.
- `imem_addr`  out  32: fetch address; stable while `imem_req`=1 and `imem_ready`=0.
- `imem_ready`  in  1: accepts the request; `imem_data` is valid in this cycle.
- `imem_data`  in  32: fetched word.
- `f_instr`, `f_pc`  out  32 each: F register.
- `f_valid`  out  1: F holds a real instruction.
- `d_instr`, `d_pc`  out  32 each: D register.
- `d_valid`  out  1: D holds a real instruction.
- `pc`  out  32: `d_pc + 4`, combinational; goes to the interrupt unit's PC input.

## Operation
- Reset values: `fetch_pc`=RESET_PC, `imem_req`=0. `f_instr`=`d_instr`=NOP. `f_pc`=`d_pc`=0. `f_valid`=`d_valid`=0. Skid buffer empty. State FETCH.
- `imem_req` rises on the first cycle after reset deasserts.
- Redirect priority, highest first: `load_pc` (target `interrupt_pc`), then `branch_taken` (target `branch_target`), then `stall`, then normal flow. When both redirects are asserted, `load_pc` wins. Neither redirect is blocked by `stall`.
- Redirect at edge N:
  - F and D become NOP with valid=0.
  - Skid buffer is emptied.
  - `fetch_pc` becomes the target.
- Normal advance, when not stalled:
  - D takes F.
  - F takes the skid entry if the skid buffer is full. Otherwise it takes `imem_data` with `f_pc`=`imem_addr` if `imem_ready`=1. Otherwise F becomes a NOP bubble.
  - `fetch_pc` += 4 on every accepted request.
- Stall with `imem_ready`=1: the word and its PC go into a 1-entry skid buffer. `imem_req`=0 while the skid buffer is full.
- States:
  - FETCH: request outstanding or issuable.
  - DISCARD: a redirect arrived while a request was outstanding and unaccepted. `imem_addr` holds the old address until `imem_ready`, the returned data is dropped, and the new target is kept in `pending_pc`.
  - Transitions: FETCH → DISCARD on a redirect with `imem_req`=1 and `imem_ready`=0. DISCARD → FETCH on `imem_ready`; the next request is at `pending_pc`.
  - A second redirect while in DISCARD overwrites `pending_pc`, with `load_pc` priority applied.
- Redirect in the same cycle as `imem_ready`: the data is dropped, DISCARD is not entered, and the next request is at the target.
- PC arithmetic: 32-bit modulo; 32'hFFFFFFFC + 4 wraps to 0.
- Reset mid-transfer: everything returns to reset values immediately. Any late `imem_ready` is ignored until `imem_req` has been re-raised.

## Timing
- Fetch latency: `imem_req` at cycle N, `imem_ready` at cycle N+k (k≥0), instruction in F at edge N+k+1 and in D one unstalled edge later.
- Redirect to first valid F: 1 cycle plus memory latency from FETCH; add the outstanding transfer's remaining latency from DISCARD.
- `load_pc` is level-sampled. A pulse held across one posedge causes exactly one redirect. A level held for multiple edges re-redirects each cycle; the interrupt unit is responsible for one-cycle pulses.
- `pc` follows D with zero latency.

## Structure
- Shared package `cpu_pkg`: `NOP` word, `RESET_PC`, the fetch state enum (FETCH, DISCARD), and the PC increment constant 4.
- One sub-module, `fetch_skid_buf`: 1-entry {instr, pc} buffer with load, pop and clear.

## Test plan
- Reset then free-run with `imem_ready` always 1:
  - `imem_addr` runs 0, 4, 8, ….
  - `f_pc` lags `imem_addr` by 1 cycle and `d_pc` by 2.
  - `pc` = `d_pc`+4.
- `load_pc`=1 with `interrupt_pc`=32'h4 while F and D are valid: next edge F/D = NOP with valid=0, then `imem_addr`=4.
- `branch_taken` (target 32'h100) and `load_pc` (32'h4) in the same cycle: fetch goes to 32'h4.
- Redirect to 32'h200 while the request at 32'h20 has `imem_ready` held low 3 cycles:
  - `imem_addr` stays at 32'h20 until ready and that data never reaches F.
  - The next request is at 32'h200.
- `stall` for 4 cycles with `imem_ready`=1:
  - One word is captured in the skid buffer and `imem_req` drops.
  - On release the skid word enters F with no loss or duplication.
- Assert `reset` asynchronously between edges mid-transfer: outputs reach reset values immediately, before the next edge.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the RISC core front end.
// Holds the NOP word injected into flushed pipeline slots, the reset PC,
// the fetch state encoding and the PC increment used by the fetch path.
package cpu_pkg;

    localparam logic [31:0] NOP      = 32'h0000_0000;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] PC_INC   = 32'd4;

    typedef enum logic {
        FETCH   = 1'b0,
        DISCARD = 1'b1
    } fetch_state_t;

    // Sequential successor of a PC; 32-bit modulo so the top word wraps to 0.
    function automatic logic [31:0] next_pc(input logic [31:0] p);
        return p + PC_INC;
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer for the fetch stage.
// Catches a word that memory delivers while the pipeline is stalled so it
// is neither lost nor re-fetched.
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   load                capture wr_instr/wr_pc and mark the entry full
//   pop                 release the entry (marks it empty)
//   clear               discard the entry; wins over load and pop
//   wr_instr, wr_pc     word and its address to capture
//   full                entry holds a valid word
//   instr, pc           the held word and its address
module fetch_skid_buf
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        pop,
    input  logic        clear,
    input  logic [31:0] wr_instr,
    input  logic [31:0] wr_pc,
    output logic        full,
    output logic [31:0] instr,
    output logic [31:0] pc
);

    // Clear has priority so a redirect always leaves the buffer empty,
    // even if memory answers in the same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            full  <= 1'b0;
            instr <= NOP;
            pc    <= RESET_PC;
        end else if (clear) begin
            full <= 1'b0;
        end else if (load) begin
            full  <= 1'b1;
            instr <= wr_instr;
            pc    <= wr_pc;
        end else if (pop) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Program counter, instruction-memory request logic and the F/D pipeline
// registers of the RISC core.
// Ports:
//   clk, reset                  clock and asynchronous active-high reset
//   stall                       hazard hold; F and D freeze
//   branch_taken/branch_target  redirect from execute
//   load_pc/interrupt_pc        redirect from the interrupt unit (wins over branch)
//   imem_req/imem_addr          fetch request and address (held until accepted)
//   imem_ready/imem_data        request accepted, word valid this cycle
//   f_instr/f_pc/f_valid        F register
//   d_instr/d_pc/d_valid        D register
//   pc                          d_pc + 4, combinational, to the interrupt unit
module fetch_stage
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        load_pc,
    input  logic [31:0] interrupt_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_data,
    output logic [31:0] f_instr,
    output logic [31:0] f_pc,
    output logic        f_valid,
    output logic [31:0] d_instr,
    output logic [31:0] d_pc,
    output logic        d_valid,
    output logic [31:0] pc
);

    fetch_state_t state, state_next;
    logic [31:0]  fetch_pc, fetch_pc_next;
    logic [31:0]  pending_pc, pending_pc_next;
    logic         active;

    logic         redirect;
    logic [31:0]  redirect_target;
    logic         accepted;
    logic         capture_ok;

    logic         skid_full;
    logic [31:0]  skid_instr;
    logic [31:0]  skid_pc;
    logic         skid_load;
    logic         skid_pop;

    // Interrupt redirect outranks branch redirect; neither is held off by stall.
    assign redirect        = load_pc | branch_taken;
    assign redirect_target = load_pc ? interrupt_pc : branch_target;

    // 'active' keeps the request low during the first cycle out of reset,
    // so a late ready from a transfer cut off by reset is never accepted.
    // In DISCARD the old request stays up until memory finishes it.
    assign imem_req  = active & ((state == DISCARD) | ~skid_full);
    assign imem_addr = fetch_pc;
    assign accepted  = imem_req & imem_ready;

    // A returned word belongs to the current instruction stream only when it
    // was not requested before a redirect and no redirect is flushing now.
    assign capture_ok = accepted & (state == FETCH) & ~redirect;
    assign skid_load  = capture_ok & stall;
    assign skid_pop   = ~redirect & ~stall & skid_full;

    assign pc = next_pc(d_pc);

    fetch_skid_buf u_skid (
        .clk      (clk),
        .reset    (reset),
        .load     (skid_load),
        .pop      (skid_pop),
        .clear    (redirect),
        .wr_instr (imem_data),
        .wr_pc    (imem_addr),
        .full     (skid_full),
        .instr    (skid_instr),
        .pc       (skid_pc)
    );

    // Fetch control: a redirect with an unaccepted request parks the target
    // in pending_pc and waits in DISCARD for the stale transfer to finish.
    always_comb begin
        state_next      = state;
        fetch_pc_next   = fetch_pc;
        pending_pc_next = pending_pc;
        case (state)
            FETCH: begin
                if (redirect) begin
                    if (imem_req && !imem_ready) begin
                        state_next      = DISCARD;
                        pending_pc_next = redirect_target;
                    end else begin
                        fetch_pc_next = redirect_target;
                    end
                end else if (accepted) begin
                    fetch_pc_next = next_pc(fetch_pc);
                end
            end
            DISCARD: begin
                if (accepted) begin
                    state_next    = FETCH;
                    fetch_pc_next = redirect ? redirect_target : pending_pc;
                end else if (redirect) begin
                    pending_pc_next = redirect_target;
                end
            end
        endcase
    end

    // Fetch state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= FETCH;
            fetch_pc   <= RESET_PC;
            pending_pc <= RESET_PC;
            active     <= 1'b0;
        end else begin
            state      <= state_next;
            fetch_pc   <= fetch_pc_next;
            pending_pc <= pending_pc_next;
            active     <= 1'b1;
        end
    end

    // F/D registers: flush on redirect, freeze on stall, otherwise D takes F
    // and F takes the skid word first, then fresh memory data, else a bubble.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            f_instr <= NOP;
            f_pc    <= 32'h0;
            f_valid <= 1'b0;
            d_instr <= NOP;
            d_pc    <= 32'h0;
            d_valid <= 1'b0;
        end else if (redirect) begin
            f_instr <= NOP;
            f_pc    <= 32'h0;
            f_valid <= 1'b0;
            d_instr <= NOP;
            d_pc    <= 32'h0;
            d_valid <= 1'b0;
        end else if (!stall) begin
            d_instr <= f_instr;
            d_pc    <= f_pc;
            d_valid <= f_valid;
            if (skid_full) begin
                f_instr <= skid_instr;
                f_pc    <= skid_pc;
                f_valid <= 1'b1;
            end else if (capture_ok) begin
                f_instr <= imem_data;
                f_pc    <= imem_addr;
                f_valid <= 1'b1;
            end else begin
                f_instr <= NOP;
                f_pc    <= 32'h0;
                f_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage.
// Reference model: the program-order instruction stream. After reset or a
// redirect to T, the instructions that reach D must be T, T+4, T+8, ...
// (32-bit wrap), each carrying the memory word at its address, with nothing
// lost or duplicated. Redirects issued by the driver rebuild the expected
// queue; a monitor pops one entry per instruction entering D.
module tb_fetch_stage;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        load_pc = 1'b0;
    logic [31:0] interrupt_pc = 32'h0;
    logic        imem_ready = 1'b0;
    logic [31:0] imem_data;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] f_instr, f_pc, d_instr, d_pc, pc;
    logic        f_valid, d_valid;

    int tests_run = 0;
    int tests_failed = 0;
    int deliveries = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .load_pc       (load_pc),
        .interrupt_pc  (interrupt_pc),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ready    (imem_ready),
        .imem_data     (imem_data),
        .f_instr       (f_instr),
        .f_pc          (f_pc),
        .f_valid       (f_valid),
        .d_instr       (d_instr),
        .d_pc          (d_pc),
        .d_valid       (d_valid),
        .pc            (pc)
    );

    // Instruction memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign imem_data = mem_word(imem_addr);

    task automatic restartStream(input logic [31:0] start);
        logic [31:0] p;
        p = start;
        exp_q.delete();
        for (int i = 0; i < 256; i++) begin
            exp_q.push_back(p);
            p = p + 32'd4;
        end
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Drives one cycle of inputs (called 2 time units after a posedge) and
    // returns 2 time units after the edge that consumed them.
    task automatic applyStimulus(input logic st, input logic rdy, input logic lp,
                                 input logic [31:0] ipc, input logic bt,
                                 input logic [31:0] bta);
        stall         = st;
        imem_ready    = rdy;
        load_pc       = lp;
        interrupt_pc  = ipc;
        branch_taken  = bt;
        branch_target = bta;
        if (lp)
            restartStream(ipc);
        else if (bt)
            restartStream(bta);
        @(posedge clk);
        #2;
    endtask

    task automatic runFree(input int n);
        for (int i = 0; i < n; i++)
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    // Monitor: inputs are changed 2 units after each edge, so at edge+1 they
    // still show what the edge just consumed.
    initial begin
        logic [31:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (!reset && !stall && !load_pc && !branch_taken && d_valid) begin
                if (exp_q.size() == 0) begin
                    tests_run++;
                    tests_failed++;
                    $display("[TB] FAIL d_stream: got pc %h, expected queue empty", d_pc);
                end else begin
                    e = exp_q.pop_front();
                    checkOutput("d_pc", d_pc, e);
                    checkOutput("d_instr", d_instr, mem_word(e));
                    checkOutput("pc_out", pc, e + 32'd4);
                    deliveries++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] t1, t2;

        // Reset state
        repeat (2) @(posedge clk);
        #2;
        checkOutput("rst_req", 32'(imem_req), 32'h0);
        checkOutput("rst_addr", imem_addr, RESET_PC);
        checkOutput("rst_f_valid", 32'(f_valid), 32'h0);
        checkOutput("rst_d_valid", 32'(d_valid), 32'h0);
        checkOutput("rst_f_instr", f_instr, NOP);
        checkOutput("rst_d_pc", d_pc, 32'h0);
        restartStream(RESET_PC);
        reset = 1'b0;

        // First edge out of reset raises the request
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("req_rise", 32'(imem_req), 32'h1);
        checkOutput("first_addr", imem_addr, 32'h0);
        checkOutput("first_f_valid", 32'(f_valid), 32'h0);

        // Free run: F lags the address by one, D by two
        for (int k = 1; k <= 8; k++) begin
            applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput("run_addr", imem_addr, 32'(4 * k));
            checkOutput("run_f_pc", f_pc, 32'(4 * (k - 1)));
            checkOutput("run_f_valid", 32'(f_valid), 32'h1);
            if (k >= 2) begin
                checkOutput("run_d_pc", d_pc, 32'(4 * (k - 2)));
                checkOutput("run_d_valid", 32'(d_valid), 32'h1);
            end
        end

        // Branch to 0x200 while the request at 0x20 is held unready 3 cycles
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h200);
        checkOutput("disc_addr0", imem_addr, 32'h20);
        checkOutput("disc_req", 32'(imem_req), 32'h1);
        checkOutput("disc_f_valid", 32'(f_valid), 32'h0);
        checkOutput("disc_d_valid", 32'(d_valid), 32'h0);
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput("disc_addr_hold", imem_addr, 32'h20);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("disc_new_addr", imem_addr, 32'h200);
        checkOutput("disc_dropped", 32'(f_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("disc_f_pc", f_pc, 32'h200);
        checkOutput("disc_f_instr", f_instr, mem_word(32'h200));
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Interrupt redirect to 0x4 while F and D hold real instructions
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 1'b0, 32'h0);
        checkOutput("irq_f_valid", 32'(f_valid), 32'h0);
        checkOutput("irq_d_valid", 32'(d_valid), 32'h0);
        checkOutput("irq_f_instr", f_instr, NOP);
        checkOutput("irq_d_instr", d_instr, NOP);
        checkOutput("irq_addr", imem_addr, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("irq_f_pc", f_pc, 32'h4);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);

        // Branch and interrupt together: interrupt target wins
        applyStimulus(1'b0, 1'b1, 1'b1, 32'h4, 1'b1, 32'h100);
        checkOutput("both_addr", imem_addr, 32'h4);
        checkOutput("both_f_valid", 32'(f_valid), 32'h0);
        runFree(3);

        // Stall 4 cycles with memory ready: one word parked, request drops
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
            checkOutput("stall_req", 32'(imem_req), 32'h0);
            checkOutput("stall_f_pc", f_pc, 32'hC);
            checkOutput("stall_d_pc", d_pc, 32'h8);
        end
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("skid_f_pc", f_pc, 32'h10);
        checkOutput("skid_f_instr", f_instr, mem_word(32'h10));
        checkOutput("skid_d_pc", d_pc, 32'hC);
        checkOutput("skid_req", 32'(imem_req), 32'h1);
        checkOutput("skid_addr", imem_addr, 32'h14);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("post_skid_f_pc", f_pc, 32'h14);
        checkOutput("post_skid_d_pc", d_pc, 32'h10);

        // PC wrap at the top of the address space
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFF8);
        checkOutput("wrap_addr0", imem_addr, 32'hFFFF_FFF8);
        runFree(2);
        checkOutput("wrap_addr2", imem_addr, 32'h0);
        runFree(3);

        // Randomized traffic
        for (int i = 0; i < 800; i++) begin
            t1 = $urandom & 32'hFFFF_FFFC;
            t2 = $urandom & 32'hFFFF_FFFC;
            if ($urandom % 4 == 0) t1 = 32'hFFFF_FFF0 | (t1 & 32'hC);
            if ($urandom % 4 == 0) t2 = 32'hFFFF_FFF0 | (t2 & 32'hC);
            applyStimulus(($urandom % 4) == 0, ($urandom % 3) != 0,
                          ($urandom % 25) == 0, t1,
                          ($urandom % 12) == 0, t2);
        end

        // Asynchronous reset between edges with a request outstanding
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
        #3;
        reset = 1'b1;
        imem_ready = 1'b1;
        #1;
        checkOutput("areset_req", 32'(imem_req), 32'h0);
        checkOutput("areset_addr", imem_addr, RESET_PC);
        checkOutput("areset_f_valid", 32'(f_valid), 32'h0);
        checkOutput("areset_d_valid", 32'(d_valid), 32'h0);
        checkOutput("areset_f_instr", f_instr, NOP);
        checkOutput("areset_d_instr", d_instr, NOP);
        checkOutput("areset_d_pc", d_pc, 32'h0);
        checkOutput("areset_pc", pc, 32'h4);
        @(posedge clk);
        #2;
        restartStream(RESET_PC);
        reset = 1'b0;
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rerun_req", 32'(imem_req), 32'h1);
        checkOutput("rerun_addr", imem_addr, 32'h0);
        checkOutput("rerun_f_valid", 32'(f_valid), 32'h0);
        applyStimulus(1'b0, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
        checkOutput("rerun_f_pc", f_pc, 32'h0);
        checkOutput("rerun_f_valid1", 32'(f_valid), 32'h1);
        runFree(4);

        checkOutput("enough_deliveries", 32'(deliveries > 100), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
